da_lut_loader: RTL and testbench

- Writer side of the distributed-arithmetic look-up table interface.
- Accepts a set of N signed coefficients through a valid/ready handshake.
- Fills the 2^N-entry partial-sum table sequentially, one entry per clock cycle.
- Provides an asynchronous read port that the bit-serial DA engine addresses with its N-bit table_in, so the table can be reprogrammed at run time instead of fixed at elaboration.

---
 rtl/da_pkg.sv | 38 +++
 rtl/da_lut_ram.sv | 30 +++
 rtl/da_lut_loader.sv | 156 +++++++++++++++
 tb/tb_da_lut_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : da_pkg                                                  |
// | Description: Shared types, default sizes, state encoding and the    |
// |              partial-sum function for the DA look-up table loader.  |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package da_pkg;

  localparam int N_DEF  = 3;
  localparam int CW_DEF = 3;
  localparam int TW_DEF = 5;

  typedef logic signed [TW_DEF-1:0] entry_t;
  typedef logic signed [CW_DEF-1:0] coef_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUILD = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Table entry for address addr: sum of the sign-extended coefficients
  // whose address bit is set. No sign-bit subtraction is applied here.
  function automatic entry_t da_entry(input logic [N_DEF-1:0]        addr,
                                      input logic [N_DEF*CW_DEF-1:0] coefs);
    entry_t s;
    coef_t  ck;
    s = '0;
    for (int k = 0; k < N_DEF; k++) begin
      ck = coefs[k*CW_DEF +: CW_DEF];
      if (addr[k]) s = s + entry_t'(ck);
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/da_lut_ram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : da_lut_ram                                              |
// | Description: 2^AW x DW table RAM, synchronous write, asynchronous   |
// |              read. Contents are not reset; the loader masks reads.  |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module da_lut_ram #(
  parameter int AW = 3,
  parameter int DW = 5
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  // One entry written per clock while the loader is building
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/da_lut_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : da_lut_loader                                           |
// | Description: Accepts N signed coefficients over valid/ready, fills  |
// |              the 2^N partial-sum table one entry per clock, and     |
// |              serves it on an asynchronous read port.                |
// |              Optional macro DA_LUT_DOUBLE_BUF_EN: two banks, the    |
// |              table stays readable while a new one is built.         |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module da_lut_loader
  import da_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF,
  parameter int TW = TW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*CW-1:0]      coef_in,
  input  logic                 load_valid,
  output logic                 load_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 table_valid,
  input  logic [N-1:0]         rd_addr,
  output logic signed [TW-1:0] rd_data
);

  state_t              state;
  state_t              state_nxt;
  logic [N-1:0]        cnt;
  logic [N*CW-1:0]     coef_q;
  logic                tv_q;
  logic                accept;
  logic                build_last;
  logic signed [CW-1:0] c_arr [N];
  logic signed [TW-1:0] wr_data;
  logic [TW-1:0]       rd_raw;

  assign accept     = (state == ST_IDLE) && load_valid;
  assign build_last = (state == ST_BUILD) && (cnt == {N{1'b1}});

  for (genvar k = 0; k < N; k++) begin : g_coef
    assign c_arr[k] = coef_q[k*CW +: CW];
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake/status outputs
  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_nxt = ST_BUILD;
      end
      ST_BUILD: begin
        busy = 1'b1;
        if (cnt == {N{1'b1}}) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Coefficient capture and build address counter (holds at the last entry)
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt    <= '0;
      coef_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      coef_q <= coef_in;
    end else if ((state == ST_BUILD) && (cnt != {N{1'b1}})) begin
      cnt <= cnt + N'(1);
    end
  end

  // Partial sum for the entry currently being written
  always_comb begin
    wr_data = '0;
    for (int k = 0; k < N; k++) begin
      if (cnt[k]) wr_data = wr_data + TW'(c_arr[k]);
    end
  end

`ifdef DA_LUT_DOUBLE_BUF_EN
  logic          bank_sel;
  logic [TW-1:0] rd0;
  logic [TW-1:0] rd1;

  // Validity survives rebuilds once a table exists; banks swap entering DONE
  always_ff @(posedge clk) begin
    if (!reset) begin
      tv_q     <= 1'b0;
      bank_sel <= 1'b0;
    end else if (build_last) begin
      tv_q     <= 1'b1;
      bank_sel <= ~bank_sel;
    end
  end

  // Bank 0 is the shadow when bank 1 is active, and vice versa
  da_lut_ram #(.AW(N), .DW(TW)) u_ram0 (
    .clk   (clk),
    .we    ((state == ST_BUILD) && bank_sel),
    .waddr (cnt),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd0)
  );

  da_lut_ram #(.AW(N), .DW(TW)) u_ram1 (
    .clk   (clk),
    .we    ((state == ST_BUILD) && !bank_sel),
    .waddr (cnt),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd1)
  );

  assign rd_raw = bank_sel ? rd1 : rd0;
`else
  // Table is invalid from the accept edge until the last entry is written
  always_ff @(posedge clk) begin
    if (!reset)          tv_q <= 1'b0;
    else if (accept)     tv_q <= 1'b0;
    else if (build_last) tv_q <= 1'b1;
  end

  da_lut_ram #(.AW(N), .DW(TW)) u_ram (
    .clk   (clk),
    .we    (state == ST_BUILD),
    .waddr (cnt),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_raw)
  );
`endif

  assign table_valid = tv_q;
  assign rd_data     = tv_q ? rd_raw : '0;

endmodule
`default_nettype wire

// File: tb/tb_da_lut_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : tb_da_lut_loader                                        |
// | Description: Scoreboard bench for da_lut_loader (N=3, CW=3, TW=5).   |
// |              Honours DA_LUT_DOUBLE_BUF_EN when defined.              |
// | Revision   : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_da_lut_loader;
  import da_pkg::*;

  logic              clk;
  logic              reset;
  logic [8:0]        coef_in;
  logic              load_valid;
  logic              load_ready;
  logic              busy;
  logic              done;
  logic              table_valid;
  logic [2:0]        rd_addr;
  logic signed [4:0] rd_data;

  entry_t exp_q[$];
  int     n_cmp;
  int     n_mis;

`ifdef DA_LUT_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  da_lut_loader dut (
    .clk         (clk),
    .reset       (reset),
    .coef_in     (coef_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .busy        (busy),
    .done        (done),
    .table_valid (table_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] pack3(input int c0, input int c1, input int c2);
    return {c2[2:0], c1[2:0], c0[2:0]};
  endfunction

  task automatic push_table(input logic [8:0] c);
    logic [2:0] a;
    for (int i = 0; i < 8; i++) begin
      a = i[2:0];
      exp_q.push_back(da_entry(a, c));
    end
  endtask

  // One address per cycle, compared against the scoreboard
  task automatic sweep_table();
    entry_t e;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rd_addr = i[2:0];
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check("rd_queue_empty", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rd_data[%0d]", i), rd_data, e);
      end
    end
  endtask

  // Present a set and wait for the accept edge; returns just after that edge
  task automatic load(input logic [8:0] c, input bit hold);
    bit acc;
    acc = 1'b0;
    coef_in    = c;
    load_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (load_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) check("accept_timeout", 0, 1);
    @(posedge clk);
    push_table(c);
    #1;
    if (!hold) load_valid = 1'b0;
  endtask

  // Called just after the accept edge; done must appear in cycle 9
  task automatic wait_done(input string tag, input bit tv_during);
    int lat;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check({tag, "_busy"}, busy, 1);
        check({tag, "_ready_build"}, load_ready, 0);
        check({tag, "_tv_build"}, table_valid, tv_during);
      end
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, lat, 9);
    check({tag, "_tv_done"}, table_valid, 1);
    check({tag, "_ready_done"}, load_ready, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_ready_idle"}, load_ready, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, load_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_tv"}, table_valid, 0);
  endtask

  initial begin
    logic [8:0] c_a, c_b, c_one;
    n_cmp      = 0;
    n_mis      = 0;
    reset      = 1'b0;
    coef_in    = '0;
    load_valid = 1'b0;
    rd_addr    = '0;
    c_a   = pack3(2, 3, 1);
    c_b   = pack3(-4, 3, -1);
    c_one = pack3(1, 1, 1);

    // Reset for two cycles, then released
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("reset");
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      rd_addr = i[2:0];
      @(negedge clk);
      check($sformatf("reset_rd[%0d]", i), rd_data, 0);
    end

    // First table: 0,2,3,5,1,3,4,6
    @(posedge clk); #1;
    load(c_a, 1'b0);
    wait_done("load_a", 1'b0);
    sweep_table();

    // Negative coefficients: 0,-4,3,-1,-1,-5,2,-2
    @(posedge clk); #1;
    load(c_b, 1'b0);
    wait_done("load_b", DB);
    sweep_table();

    // load_valid held through a build: second set accepted only after DONE
    @(posedge clk); #1;
    load(c_a, 1'b1);
    coef_in = c_one;
    wait_done("hold_1", DB);
    exp_q.delete();
    @(posedge clk);
    push_table(c_one);
    #1 load_valid = 1'b0;
    wait_done("hold_2", DB);
    sweep_table();

    // Reset asserted on the fourth write cycle aborts the build
    @(posedge clk); #1;
    load(c_b, 1'b0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    rd_addr = 3'd5;
    #1 check("abort_rd", rd_data, 0);
    @(posedge clk); #1 reset = 1'b1;
    load(c_a, 1'b0);
    wait_done("reload", 1'b0);
    sweep_table();

`ifdef DA_LUT_DOUBLE_BUF_EN
    // Rebuild while reading: old table through BUILD, new from DONE on
    begin
      entry_t e;
      logic [2:0] a;
      @(posedge clk); #1;
      load(c_b, 1'b0);
      for (int i = 1; i <= 9; i++) begin
        a       = i[2:0];
        rd_addr = a;
        @(negedge clk);
        e = (i < 9) ? da_entry(a, c_a) : da_entry(a, c_b);
        check($sformatf("db_rd[%0d]", i), rd_data, e);
        check($sformatf("db_tv[%0d]", i), table_valid, 1);
        check($sformatf("db_done[%0d]", i), done, (i == 9) ? 1 : 0);
        @(posedge clk); #1;
      end
      sweep_table();
    end
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
